// File: rtl/mul_hash_arbiter.sv
// Round-robin front end sharing one fixed-latency mul_hash pipe between NREQ key requesters.
// Define MUL_HASH_ARB_STATS_EN to add the grant/stall statistics counters and their ports.
module mul_hash_arbiter #(
    parameter int NREQ       = 4,
    parameter int NBITS      = 15,
    parameter int HASH_LAT   = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*64-1:0]      req_key,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [NBITS-1:0]        res_hash,
    input  logic                    res_ready,
    output logic                    hash_ce,
    output logic [63:0]             hash_a,
    output logic                    hash_in_v,
    input  logic [NBITS-1:0]        hash_p,
    input  logic                    hash_out_v,
    output logic                    tag_err
`ifdef MUL_HASH_ARB_STATS_EN
    ,
    input  logic [$clog2(NREQ)-1:0] stat_sel,
    output logic [31:0]             stat_grants,
    output logic [31:0]             stat_stall
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int DW  = IDW + NBITS;

    logic               run_reg;
    logic [IDW-1:0]     ptr_reg;
    logic [IDW-1:0]     grant;
    logic [IDW-1:0]     idx;
    logic               any_valid;
    logic               credit_ok;
    logic               accept;
    logic               pop;
    logic               push;
    logic               drop;
    logic [CW-1:0]      used_reg;
    logic               hash_in_v_reg;
    logic [63:0]        hash_a_reg;
    logic [IDW-1:0]     issue_id_reg;
    logic               tag_err_reg;
    logic [IDW:0]       tag_reg [HASH_LAT];
    logic               tag_v;
    logic [IDW-1:0]     tag_id;

    // Descending scan: the last hit written is the first requester after ptr_reg.
    always_comb begin
        grant = ptr_reg;
        idx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr_reg) + k) % NREQ);
            if (req_valid[idx]) grant = idx;
        end
    end

    // A pop in the same cycle frees a credit, so a full pipe keeps issuing 1/cycle.
    assign any_valid = |req_valid;
    assign credit_ok = (used_reg < CW'(FIFO_DEPTH)) || pop;
    assign accept    = run_reg && any_valid && credit_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant == IDW'(gi));
        end
    endgenerate

    assign tag_v  = tag_reg[HASH_LAT-1][IDW];
    assign tag_id = tag_reg[HASH_LAT-1][IDW-1:0];
    assign push   = hash_out_v && tag_v;
    assign drop   = tag_v && !hash_out_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg       <= 1'b0;
            ptr_reg       <= IDW'(NREQ - 1);
            hash_in_v_reg <= 1'b0;
            hash_a_reg    <= '0;
            issue_id_reg  <= '0;
            used_reg      <= '0;
            tag_err_reg   <= 1'b0;
            for (int i = 0; i < HASH_LAT; i++) tag_reg[i] <= '0;
        end else begin
            run_reg       <= 1'b1;
            hash_in_v_reg <= accept;
            if (accept) begin
                ptr_reg      <= grant;
                hash_a_reg   <= req_key[64*grant +: 64];
                issue_id_reg <= grant;
            end
            used_reg <= used_reg + CW'(accept) - CW'(pop) - CW'(drop);
            if (hash_out_v != tag_v) tag_err_reg <= 1'b1;
            tag_reg[0] <= {hash_in_v_reg, issue_id_reg};
            for (int i = 1; i < HASH_LAT; i++) tag_reg[i] <= tag_reg[i-1];
        end
    end

    // Result FIFO: storage array plus an output register that doubles as the registered read.
    logic [DW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  cnt_reg;
    logic           res_valid_reg;
    logic [DW-1:0]  out_data_reg;
    logic [DW-1:0]  push_data;
    logic           out_load;
    logic           mem_rd;
    logic           mem_wr;
    logic           bypass;

    assign push_data = {tag_id, hash_p};
    assign pop       = res_valid_reg && res_ready;
    assign out_load  = !res_valid_reg || pop;
    assign mem_rd    = out_load && (cnt_reg != '0);
    assign bypass    = out_load && (cnt_reg == '0) && push;
    assign mem_wr    = push && !bypass;

    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            cnt_reg       <= '0;
            res_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (mem_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (mem_rd) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            cnt_reg <= cnt_reg + CW'(mem_wr) - CW'(mem_rd);
            if (out_load) begin
                res_valid_reg <= mem_rd || push;
                if (mem_rd)    out_data_reg <= mem[rd_ptr_reg];
                else if (push) out_data_reg <= push_data;
            end
        end
    end

    assign hash_ce   = run_reg;
    assign hash_a    = hash_a_reg;
    assign hash_in_v = hash_in_v_reg;
    assign res_valid = res_valid_reg;
    assign res_id    = out_data_reg[DW-1:NBITS];
    assign res_hash  = out_data_reg[NBITS-1:0];
    assign tag_err   = tag_err_reg;

`ifdef MUL_HASH_ARB_STATS_EN
    logic [31:0] grant_cnt_reg [NREQ];
    logic [31:0] stall_cnt_reg;
    logic [31:0] stat_grants_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) grant_cnt_reg[i] <= '0;
            stall_cnt_reg   <= '0;
            stat_grants_reg <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && grant == IDW'(i) && grant_cnt_reg[i] != '1)
                    grant_cnt_reg[i] <= grant_cnt_reg[i] + 32'd1;
            end
            if (any_valid && !credit_ok && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            stat_grants_reg <= grant_cnt_reg[stat_sel];
        end
    end

    assign stat_grants = stat_grants_reg;
    assign stat_stall  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_mul_hash_arbiter.sv
// Bench for mul_hash_arbiter: behavioural mul_hash stand-in, grant/credit model and result scoreboard.
module tb_mul_hash_arbiter;
    localparam int NREQ       = 4;
    localparam int NBITS      = 15;
    localparam int HASH_LAT   = 11;
    localparam int FIFO_DEPTH = 16;
    localparam int IDW        = $clog2(NREQ);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*64-1:0]  req_key = '0;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic [IDW-1:0]      res_id;
    logic [NBITS-1:0]    res_hash;
    logic                res_ready = 1'b1;
    logic                hash_ce;
    logic [63:0]         hash_a;
    logic                hash_in_v;
    logic [NBITS-1:0]    hash_p;
    logic                hash_out_v;
    logic                tag_err;
`ifdef MUL_HASH_ARB_STATS_EN
    logic [IDW-1:0]      stat_sel = '0;
    logic [31:0]         stat_grants;
    logic [31:0]         stat_stall;
`endif

    always #5 clk = ~clk;

    mul_hash_arbiter #(.NREQ(NREQ), .NBITS(NBITS), .HASH_LAT(HASH_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .res_valid(res_valid), .res_id(res_id), .res_hash(res_hash), .res_ready(res_ready),
        .hash_ce(hash_ce), .hash_a(hash_a), .hash_in_v(hash_in_v),
        .hash_p(hash_p), .hash_out_v(hash_out_v), .tag_err(tag_err)
`ifdef MUL_HASH_ARB_STATS_EN
        , .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [NBITS-1:0] ref_hash(input logic [63:0] k);
        logic [63:0] prod;
        prod = k * 64'h9E3779B97F4A7C15;
        return prod[63:64-NBITS];
    endfunction

    // mul_hash stand-in: never reset, ignores ce, fixed HASH_LAT latency.
    logic [NBITS:0] mh_pipe [HASH_LAT];
    always @(posedge clk) begin
        mh_pipe[0] <= {hash_in_v, ref_hash(hash_a)};
        for (int i = 1; i < HASH_LAT; i++) mh_pipe[i] <= mh_pipe[i-1];
    end
    assign hash_out_v = mh_pipe[HASH_LAT-1][NBITS];
    assign hash_p     = mh_pipe[HASH_LAT-1][NBITS-1:0];

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        logic [IDW-1:0]   id;
        logic [NBITS-1:0] h;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   acc_total = 0;
    int   pop_total = 0;
    int   res_seen = 0;
    int   stall_m = 0;
    int   ptr_m = NREQ - 1;
    int   grant_m [NREQ];
    logic run_m;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_m <= 1'b0;
        else        run_m <= 1'b1;
    end

    always @(negedge clk) begin
        logic            pop_now;
        logic            credit_m;
        logic [NREQ-1:0] exp_rdy;
        logic [IDW-1:0]  cand;
        int              gm;
        exp_t            e;
        if (!rst_n) begin
            sbq.delete();
            ptr_m   = NREQ - 1;
            stall_m = 0;
            for (int i = 0; i < NREQ; i++) grant_m[i] = 0;
            check_val("rst_req_ready", 64'(req_ready), 64'd0);
        end else begin
            pop_now  = res_valid && res_ready;
            credit_m = (sbq.size() < FIFO_DEPTH) || pop_now;
            gm = -1;
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDW'((ptr_m + k) % NREQ);
                if (gm < 0 && req_valid[cand]) gm = int'(cand);
            end
            exp_rdy = '0;
            if (run_m && credit_m && gm >= 0) begin
                exp_rdy[gm] = 1'b1;
                ptr_m = gm;
            end
            check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
            if (!credit_m && |req_valid) stall_m++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = IDW'(i);
                    e.h  = ref_hash(req_key[64*i +: 64]);
                    sbq.push_back(e);
                    acc_total++;
                    grant_m[i]++;
                    $display("accept id=%0d key=%016h cyc=%0d", i, req_key[64*i +: 64], cyc);
                end
            end
            if (res_valid) res_seen++;
            if (pop_now) begin
                if (sbq.size() == 0) begin
                    check_val("res_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check_val("res_id", 64'(res_id), 64'(e.id));
                    check_val("res_hash", 64'(res_hash), 64'(e.h));
                    pop_total++;
                    $display("result id=%0d hash=%0h cyc=%0d", res_id, res_hash, cyc);
                end
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) req_key[64*i +: 64] = {$urandom(), $urandom()};
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_val(tag, 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   t_acc, b_acc, b_pop, b_res, b_acc4;
        int   b_g [NREQ];
        logic got;

        // Reset values while reset is held, with every requester asking.
        repeat (15) @(posedge clk);
        #1;
        req_valid = '1;
        #1;
        check_val("rst_hash_ce", 64'(hash_ce), 64'd0);
        check_val("rst_hash_in_v", 64'(hash_in_v), 64'd0);
        check_val("rst_hash_a", hash_a, 64'd0);
        check_val("rst_res_valid", 64'(res_valid), 64'd0);
        check_val("rst_tag_err", 64'(tag_err), 64'd0);
        check_val("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        rst_n = 1'b1;
        repeat (3) step_cycle();
        @(negedge clk);
        check_val("run_hash_ce", 64'(hash_ce), 64'd1);

        // Single key on requester 2, latency to res_valid.
        @(posedge clk);
        #1;
        req_key[128 +: 64] = 64'h0123456789abcdef;
        req_valid = 4'b0100;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[2]) got = 1'b1;
        end
        t_acc = cyc;
        check_val("t1_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (res_valid) got = 1'b1;
        end
        check_val("t1_res_seen", 64'(got), 64'd1);
        check_val("t1_latency", 64'(cyc - t_acc), 64'd13);
        wait_drain("t1_drain");

        // All requesters for 40 cycles.
        @(posedge clk);
        #1;
        req_valid = '1;
        b_acc = acc_total;
        for (int i = 0; i < NREQ; i++) b_g[i] = grant_m[i];
        repeat (39) step_cycle();
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check_val("t2_accepts", 64'(acc_total - b_acc), 64'd40);
        for (int i = 0; i < NREQ; i++) check_val($sformatf("t2_grants_%0d", i), 64'(grant_m[i] - b_g[i]), 64'd10);
        wait_drain("t2_drain");
`ifdef MUL_HASH_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            @(posedge clk);
            #1;
            stat_sel = IDW'(i);
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_val($sformatf("stat_grants_%0d", i), 64'(stat_grants), 64'(grant_m[i]));
        end
`endif

        // Consumer stalled: exactly FIFO_DEPTH keys accepted.
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        req_valid = '1;
        b_acc = acc_total;
        b_pop = pop_total;
        repeat (39) step_cycle();
        @(negedge clk);
        check_val("t3_ready_low", 64'(req_ready), 64'd0);
        check_val("t3_res_valid", 64'(res_valid), 64'd1);

        // Release consumer with requests still pending: issue and pop every cycle.
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        check_val("t3_accepts", 64'(acc_total - b_acc), 64'd16);
        b_acc4 = acc_total;
        repeat (29) step_cycle();
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check_val("t4_accepts", 64'(acc_total - b_acc4), 64'd30);
        wait_drain("t4_drain");
        check_val("t4_none_lost", 64'(pop_total - b_pop), 64'(acc_total - b_acc));
`ifdef MUL_HASH_ARB_STATS_EN
        check_val("stat_stall", 64'(stat_stall), 64'(stall_m));
`endif

        // Reset with 8 keys in flight.
        @(posedge clk);
        #1;
        req_valid = '1;
        repeat (7) step_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        check_val("t5_hash_ce", 64'(hash_ce), 64'd0);
        check_val("t5_hash_in_v", 64'(hash_in_v), 64'd0);
        check_val("t5_hash_a", hash_a, 64'd0);
        check_val("t5_res_valid", 64'(res_valid), 64'd0);
        check_val("t5_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b_res = res_seen;
        repeat (25) step_cycle();
        @(negedge clk);
        check_val("t5_no_result", 64'(res_seen - b_res), 64'd0);
        check_val("t5_tag_err_set", 64'(tag_err), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step_cycle();
        @(negedge clk);
        check_val("t5_tag_err_clr", 64'(tag_err), 64'd0);

        // Operation resumes after the resets.
        @(posedge clk);
        #1;
        b_pop = pop_total;
        req_key[64 +: 64] = 64'hfedcba9876543210;
        req_valid = 4'b0010;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[1]) got = 1'b1;
        end
        check_val("t5_resume_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_drain("t5_drain");
        check_val("t5_resume_result", 64'(pop_total - b_pop), 64'd1);
        check_val("t5_tag_err_final", 64'(tag_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
